// File: rtl/multicycle_ctrl_pkg.sv
// ============================================================================
// Module      : multicycle_ctrl_pkg
// Description : State, select, opcode and funct codes shared by the
//               multi-cycle MIPS control unit and its decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_TRAP = 3'd5
    } state_e;

    localparam logic [2:0] ALU_NOP  = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;
    localparam logic [2:0] ALU_SLT  = 3'd5;
    localparam logic [2:0] ALU_SLTU = 3'd6;

    localparam logic [1:0] NPC_PLUS4  = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;

    localparam logic [1:0] GPR_RD  = 2'd0;
    localparam logic [1:0] GPR_RT  = 2'd1;
    localparam logic [1:0] GPR_R31 = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // One-hot instruction class bit positions
    localparam int CLS_R    = 0;
    localparam int CLS_ADDI = 1;
    localparam int CLS_ORI  = 2;
    localparam int CLS_LW   = 3;
    localparam int CLS_SW   = 4;
    localparam int CLS_BEQ  = 5;
    localparam int CLS_BNE  = 6;
    localparam int CLS_J    = 7;
    localparam int CLS_JAL  = 8;
    localparam int CLS_W    = 9;

    typedef logic [CLS_W-1:0] cls_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_dec.sv
// ============================================================================
// Module      : multicycle_ctrl_dec
// Description : Combinational Op/Funct decoder: one-hot class, ALU op, legal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output cls_t       cls_o,
    output logic [2:0] alu_op_o,
    output logic       legal_o
);

    always_comb begin
        cls_o    = '0;
        alu_op_o = ALU_NOP;
        case (op_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_ADDU: begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_ADD;  end
                    FN_SUB, FN_SUBU: begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_SUB;  end
                    FN_AND:          begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_AND;  end
                    FN_OR:           begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_OR;   end
                    FN_SLT:          begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_SLT;  end
                    FN_SLTU:         begin cls_o[CLS_R] = 1'b1; alu_op_o = ALU_SLTU; end
                    default: ;
                endcase
            end
            OP_ADDI: begin cls_o[CLS_ADDI] = 1'b1; alu_op_o = ALU_ADD; end
            OP_ORI:  begin cls_o[CLS_ORI]  = 1'b1; alu_op_o = ALU_OR;  end
            OP_LW:   begin cls_o[CLS_LW]   = 1'b1; alu_op_o = ALU_ADD; end
            OP_SW:   begin cls_o[CLS_SW]   = 1'b1; alu_op_o = ALU_ADD; end
            OP_BEQ:  begin cls_o[CLS_BEQ]  = 1'b1; alu_op_o = ALU_SUB; end
            OP_BNE:  begin cls_o[CLS_BNE]  = 1'b1; alu_op_o = ALU_SUB; end
            OP_J:    cls_o[CLS_J]   = 1'b1;
            OP_JAL:  cls_o[CLS_JAL] = 1'b1;
            default: ;
        endcase
        legal_o = |cls_o;
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with a shared
//               variable-latency memory port. Define MULTICYCLE_CTRL_TRAP_EN
//               to enable the TRAP state, sticky illegal flag and wait limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUOP_W      = 3,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               EXTOp,
    output logic               ALUSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         NPCOp,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic [2:0]         state,
    output logic               illegal
);

    state_e     state_q, state_d;
    cls_t       w_cls;
    logic [2:0] w_dec_alu;
    logic       w_legal;

    logic       w_pcwrite, w_irwrite, w_memread, w_memwrite, w_regwrite;
    logic       w_extop, w_alusrc;
    logic [2:0] w_alu_op;
    logic [1:0] w_npcop, w_gprsel, w_wdsel;

    multicycle_ctrl_dec u_dec (
        .op_i     (Op),
        .funct_i  (Funct),
        .cls_o    (w_cls),
        .alu_op_o (w_dec_alu),
        .legal_o  (w_legal)
    );

`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam int WCNT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    logic [WCNT_W-1:0] wait_q, wait_d;
    logic              w_wait_expired;

    // wait_q holds the number of wait cycles already spent in this state
    assign w_wait_expired = (MEM_WAIT_MAX != 0) && (wait_q == WCNT_W'(MEM_WAIT_MAX));

    always_comb begin
        wait_d = '0;
        if (((state_q == ST_IF) || (state_q == ST_MEM)) && !mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (MEM_WAIT_MAX != 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_extop    = 1'b0;
        w_alusrc   = 1'b0;
        w_alu_op   = ALU_NOP;
        w_npcop    = NPC_PLUS4;
        w_gprsel   = GPR_RD;
        w_wdsel    = WD_ALU;

        // No ALUOut register: the ALU controls stay live through MEM and WB
        if ((state_q == ST_EX) || (state_q == ST_MEM) || (state_q == ST_WB)) begin
            w_alu_op = w_dec_alu;
            w_alusrc = w_cls[CLS_ADDI] | w_cls[CLS_ORI] | w_cls[CLS_LW] | w_cls[CLS_SW];
            w_extop  = w_cls[CLS_ADDI] | w_cls[CLS_LW]  | w_cls[CLS_SW] |
                       w_cls[CLS_BEQ]  | w_cls[CLS_BNE];
        end

        case (state_q)
            ST_IF: begin
                w_memread = 1'b1;
                if (mem_ready) begin
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    w_npcop   = NPC_PLUS4;
                    state_d   = ST_ID;
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                else if (w_wait_expired) begin
                    state_d = ST_TRAP;
                end
`endif
            end
            ST_ID: begin
                if (w_cls[CLS_J] || w_cls[CLS_JAL]) begin
                    w_pcwrite = 1'b1;
                    w_npcop   = NPC_JUMP;
                    state_d   = ST_IF;
                    if (w_cls[CLS_JAL]) begin
                        w_regwrite = 1'b1;
                        w_gprsel   = GPR_R31;
                        w_wdsel    = WD_PC;
                    end
                end else if (w_legal) begin
                    state_d = ST_EX;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_d = ST_TRAP;
`else
                    state_d = ST_IF;
`endif
                end
            end
            ST_EX: begin
                if (w_cls[CLS_BEQ] || w_cls[CLS_BNE]) begin
                    w_pcwrite = (w_cls[CLS_BEQ] & Zero) | (w_cls[CLS_BNE] & ~Zero);
                    w_npcop   = NPC_BRANCH;
                    state_d   = ST_IF;
                end else if (w_cls[CLS_LW] || w_cls[CLS_SW]) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                w_memread  = w_cls[CLS_LW];
                w_memwrite = w_cls[CLS_SW];
                if (mem_ready) begin
                    state_d = w_cls[CLS_LW] ? ST_WB : ST_IF;
                end
`ifdef MULTICYCLE_CTRL_TRAP_EN
                else if (w_wait_expired) begin
                    state_d = ST_TRAP;
                end
`endif
            end
            ST_WB: begin
                w_regwrite = 1'b1;
                w_gprsel   = w_cls[CLS_R]  ? GPR_RD : GPR_RT;
                w_wdsel    = w_cls[CLS_LW] ? WD_MEM : WD_ALU;
                state_d    = ST_IF;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_IF;
        endcase
    end

    // Everything is forced low while reset is asserted so no request escapes
    assign PCWrite  = rstn & w_pcwrite;
    assign IRWrite  = rstn & w_irwrite;
    assign MemRead  = rstn & w_memread;
    assign MemWrite = rstn & w_memwrite;
    assign RegWrite = rstn & w_regwrite;
    assign EXTOp    = rstn & w_extop;
    assign ALUSrc   = rstn & w_alusrc;
    assign ALUOp    = rstn ? ALUOP_W'(w_alu_op) : '0;
    assign NPCOp    = rstn ? w_npcop  : 2'd0;
    assign GPRSel   = rstn ? w_gprsel : 2'd0;
    assign WDSel    = rstn ? w_wdsel  : 2'd0;
    assign state    = rstn ? state_q  : 3'd0;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal  = rstn & (state_q == ST_TRAP);
`else
    assign illegal  = 1'b0;
`endif

endmodule

`default_nettype wire
